// File: rtl/tetris_renderer.sv
// Tetris pixel compositor: board cells, score digits and background over a
// fixed-latency pipeline, with a line-clear row-flash sequencer.
module tetris_renderer #(
   parameter int BOARD_COLS   = 10,
   parameter int BOARD_ROWS   = 20,
   parameter int CELL_PX      = 20,
   parameter int BOARD_X0     = 220,
   parameter int BOARD_Y0     = 40,
   parameter int BLOCK_W      = 10,
   parameter int NUM_W        = 5,
   parameter int NUM_H        = 9,
   parameter int SCALE        = 2,
   parameter int SCORE_DIGITS = 4,
   parameter int DIGIT_X0     = 128,
   parameter int DIGIT_Y0     = 450,
   parameter int DIGIT_PITCH  = 14,
   parameter int LZ_BLANK     = 1,
   parameter int FLASH_FRAMES = 8,
   parameter int BG_W         = 320
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        p_tick_i,
   input  logic                        visible_i,
   input  logic [9:0]                  pixel_x_i,
   input  logic [9:0]                  pixel_y_i,
   input  logic                        frame_start_i,
   output logic [3:0]                  cell_x_o,
   output logic [4:0]                  cell_y_o,
   input  logic [2:0]                  kind_i,
   input  logic [4*SCORE_DIGITS-1:0]   score_i,
   input  logic                        flash_start_i,
   input  logic [BOARD_ROWS-1:0]       flash_rows_i,
   output logic                        flash_busy_o,
   output logic                        flash_done_o,
   output logic [17:0]                 spr_addr_o,
   input  logic [11:0]                 spr_data_i,
   output logic [17:0]                 bg_addr_o,
   input  logic [11:0]                 bg_data_i,
   output logic [11:0]                 rgb_o
);

   localparam int CNT_W = (FLASH_FRAMES > 2) ? $clog2(FLASH_FRAMES) : 1;
   localparam int IDX_W = (SCORE_DIGITS > 1) ? $clog2(SCORE_DIGITS) : 1;

   localparam logic [9:0]  BX0    = 10'(BOARD_X0);
   localparam logic [9:0]  BX1    = 10'(BOARD_X0 + BOARD_COLS * CELL_PX);
   localparam logic [9:0]  BY0    = 10'(BOARD_Y0);
   localparam logic [9:0]  BY1    = 10'(BOARD_Y0 + BOARD_ROWS * CELL_PX);
   localparam logic [9:0]  CELL_P = 10'(CELL_PX);
   localparam logic [9:0]  DY0    = 10'(DIGIT_Y0);
   localparam logic [9:0]  DY1    = 10'(DIGIT_Y0 + NUM_H * SCALE);
   localparam logic [9:0]  DIG_WP = 10'(NUM_W * SCALE);
   localparam logic [9:0]  SC     = 10'(SCALE);
   localparam logic [17:0] BLK_SZ   = 18'(BLOCK_W * BLOCK_W);
   localparam logic [17:0] DIG_BASE = 18'(7 * BLOCK_W * BLOCK_W);
   localparam logic [17:0] DIG_SZ   = 18'(NUM_W * NUM_H);
   localparam logic [17:0] BLK_W18  = 18'(BLOCK_W);
   localparam logic [17:0] NUM_W18  = 18'(NUM_W);
   localparam logic [17:0] BG_W18   = 18'(BG_W);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FLASH_FRAMES - 1);

   typedef enum logic {IDLE, FLASH} state_t;

   state_t                state_q;
   logic [BOARD_ROWS-1:0] mask_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  phase_q;

   // S0 decode results
   logic             s0_board_d, s0_digit_d;
   logic [IDX_W-1:0] s0_idx_d;
   logic [3:0]       cell_x_d;
   logic [4:0]       cell_y_d;
   logic [9:0]       off_x_d, off_y_d, bx, by, dx;
   // S0 registers (cell_x_o/cell_y_o belong to this stage)
   logic             s0_board_q, s0_digit_q, s0_vis_q;
   logic [IDX_W-1:0] s0_idx_q;
   logic [9:0]       s0_off_x_q, s0_off_y_q, s0_px_q, s0_py_q;
   // S1 registers: aligned with kind_i
   logic             s1_board_q, s1_digit_q, s1_vis_q, s1_flash_q;
   logic [IDX_W-1:0] s1_idx_q;
   logic [9:0]       s1_off_x_q, s1_off_y_q, s1_px_q, s1_py_q;
   // address formation
   logic             lead, blank, src_d;
   logic [3:0]       nib, dig;
   logic [17:0]      spr_addr_d, bg_addr_d;
   // S2/S3 flags riding alongside the ROM lookups
   logic             s2_src_q, s2_vis_q, s2_flash_q;
   logic             s3_src_q, s3_vis_q, s3_flash_q;
   logic [11:0]      rgb_pipe_d, rgb_pipe_q;

   // Classify the incoming pixel into board / digit / nothing and find its offsets.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      s0_board_d = 1'b0;
      s0_digit_d = 1'b0;
      s0_idx_d   = '0;
      cell_x_d   = '0;
      cell_y_d   = '0;
      off_x_d    = '0;
      off_y_d    = '0;
      dx         = '0;
      bx         = pixel_x_i - BX0;
      by         = pixel_y_i - BY0;
      if (pixel_x_i >= BX0 && pixel_x_i < BX1 && pixel_y_i >= BY0 && pixel_y_i < BY1) begin
         s0_board_d = 1'b1;
         cell_x_d   = 4'(bx / CELL_P);
         cell_y_d   = 5'(by / CELL_P);
         off_x_d    = bx % CELL_P;
         off_y_d    = by % CELL_P;
      end else if (pixel_y_i >= DY0 && pixel_y_i < DY1) begin
         off_y_d = pixel_y_i - DY0;
         for (int n = 0; n < SCORE_DIGITS; n++) begin
            dx = pixel_x_i - 10'(DIGIT_X0 + n * DIGIT_PITCH);
            if (pixel_x_i >= 10'(DIGIT_X0 + n * DIGIT_PITCH) && dx < DIG_WP) begin
               s0_digit_d = 1'b1;
               s0_idx_d   = IDX_W'(n);
               off_x_d    = dx;
            end
         end
      end
   end

   // S0 and S1 registers: region, offsets and the board lookup address.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking only, so each stage takes the previous stage's old value.
      if (!reset_n) begin
         s0_board_q <= 1'b0;  s0_digit_q <= 1'b0;  s0_vis_q <= 1'b0;  s0_idx_q <= '0;
         s0_off_x_q <= '0;    s0_off_y_q <= '0;    s0_px_q  <= '0;    s0_py_q  <= '0;
         cell_x_o   <= '0;    cell_y_o   <= '0;
         s1_board_q <= 1'b0;  s1_digit_q <= 1'b0;  s1_vis_q <= 1'b0;  s1_flash_q <= 1'b0;
         s1_idx_q   <= '0;    s1_off_x_q <= '0;    s1_off_y_q <= '0;
         s1_px_q    <= '0;    s1_py_q    <= '0;
      end else begin
         s0_board_q <= s0_board_d;  s0_digit_q <= s0_digit_d;  s0_vis_q <= visible_i;
         s0_idx_q   <= s0_idx_d;    s0_off_x_q <= off_x_d;     s0_off_y_q <= off_y_d;
         s0_px_q    <= pixel_x_i;   s0_py_q    <= pixel_y_i;
         cell_x_o   <= cell_x_d;    cell_y_o   <= cell_y_d;
         s1_board_q <= s0_board_q;  s1_digit_q <= s0_digit_q;  s1_vis_q <= s0_vis_q;
         s1_flash_q <= s0_board_q && phase_q && mask_q[cell_y_o];
         s1_idx_q   <= s0_idx_q;    s1_off_x_q <= s0_off_x_q;  s1_off_y_q <= s0_off_y_q;
         s1_px_q    <= s0_px_q;     s1_py_q    <= s0_py_q;
      end
   end

   // Pick the digit nibble, apply leading-zero blanking, and form both ROM addresses.
   always_comb begin
      lead  = 1'b1;
      blank = 1'b0;
      nib   = '0;
      dig   = '0;
      for (int n = 0; n < SCORE_DIGITS; n++) begin
         dig = score_i[4*(SCORE_DIGITS-1-n) +: 4];
         if (dig != 4'd0) lead = 1'b0;
         if (IDX_W'(n) == s1_idx_q) begin
            nib   = dig;
            blank = lead && (n != SCORE_DIGITS - 1) && (LZ_BLANK != 0);
         end
      end
      src_d = (s1_board_q && kind_i != 3'd0) || (s1_digit_q && nib <= 4'd9 && !blank);
      if (s1_board_q)
         spr_addr_d = (18'(kind_i) - 18'd1) * BLK_SZ + 18'(s1_off_y_q / SC) * BLK_W18
                    + 18'(s1_off_x_q / SC);
      else
         spr_addr_d = DIG_BASE + 18'(nib) * DIG_SZ + 18'(s1_off_y_q / SC) * NUM_W18
                    + 18'(s1_off_x_q / SC);
      bg_addr_d = 18'(s1_py_q / SC) * BG_W18 + 18'(s1_px_q / SC);
   end

   // Transparent sprite pixels and empty sources fall through to the background.
   always_comb begin
      rgb_pipe_d = bg_data_i;
      if (!s3_vis_q)                           rgb_pipe_d = 12'h000;
      else if (s3_flash_q)                     rgb_pipe_d = 12'hfff;
      else if (s3_src_q && spr_data_i != 12'hfff) rgb_pipe_d = spr_data_i;
   end

   // S2/S3 registers, the composite, and the p_tick-gated output.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         spr_addr_o <= '0;    bg_addr_o <= '0;
         s2_src_q   <= 1'b0;  s2_vis_q  <= 1'b0;  s2_flash_q <= 1'b0;
         s3_src_q   <= 1'b0;  s3_vis_q  <= 1'b0;  s3_flash_q <= 1'b0;
         rgb_pipe_q <= '0;    rgb_o     <= '0;
      end else begin
         spr_addr_o <= spr_addr_d;  bg_addr_o <= bg_addr_d;
         s2_src_q   <= src_d;       s2_vis_q  <= s1_vis_q;  s2_flash_q <= s1_flash_q;
         s3_src_q   <= s2_src_q;    s3_vis_q  <= s2_vis_q;  s3_flash_q <= s2_flash_q;
         rgb_pipe_q <= rgb_pipe_d;
         if (p_tick_i) rgb_o <= rgb_pipe_q;
      end
   end

   // Row-flash sequencer: phase toggles per frame, ends after FLASH_FRAMES frames.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         flash_busy_o <= 1'b0;
         flash_done_o <= 1'b0;
         mask_q       <= '0;
         cnt_q        <= '0;
         phase_q      <= 1'b0;
      end else begin
         flash_done_o <= 1'b0;
         case (state_q)
            IDLE: if (flash_start_i && |flash_rows_i) begin
               state_q      <= FLASH;
               flash_busy_o <= 1'b1;
               mask_q       <= flash_rows_i;
               cnt_q        <= '0;
               phase_q      <= 1'b0;
            end
            FLASH: if (frame_start_i) begin
               if (cnt_q == LAST_CNT) begin
                  state_q      <= IDLE;
                  flash_busy_o <= 1'b0;
                  flash_done_o <= 1'b1;
                  phase_q      <= 1'b0;
               end else begin
                  cnt_q   <= cnt_q + 1'b1;
                  phase_q <= ~phase_q;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tetris_renderer.sv
// Self-checking bench for tetris_renderer: directed scenarios plus random
// pixel probes compared against a screen-geometry reference model.
module tb_tetris_renderer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        p_tick = 1'b0;
   logic        visible = 1'b0;
   logic [9:0]  pixel_x = '0;
   logic [9:0]  pixel_y = '0;
   logic        frame_start = 1'b0;
   logic [3:0]  cell_x;
   logic [4:0]  cell_y;
   logic [2:0]  kind = '0;
   logic [15:0] score = '0;
   logic        flash_start = 1'b0;
   logic [19:0] flash_rows = '0;
   logic        flash_busy, flash_done;
   logic [17:0] spr_addr, bg_addr;
   logic [11:0] spr_data = '0;
   logic [11:0] bg_data = '0;
   logic [11:0] rgb;

   int          n_checks = 0;
   int          n_fails  = 0;
   int          tick_cnt = 0;
   int          board [20][10];
   bit          m_active = 1'b0;
   int          m_cnt = 0;
   logic [19:0] m_mask = '0;

   tetris_renderer dut (
      .clk(clk), .reset_n(reset_n), .p_tick_i(p_tick), .visible_i(visible),
      .pixel_x_i(pixel_x), .pixel_y_i(pixel_y), .frame_start_i(frame_start),
      .cell_x_o(cell_x), .cell_y_o(cell_y), .kind_i(kind), .score_i(score),
      .flash_start_i(flash_start), .flash_rows_i(flash_rows),
      .flash_busy_o(flash_busy), .flash_done_o(flash_done),
      .spr_addr_o(spr_addr), .spr_data_i(spr_data),
      .bg_addr_o(bg_addr), .bg_data_i(bg_data), .rgb_o(rgb)
   );

   always #5 clk = ~clk;

   // ROM contents: every fifth sprite word is transparent
   function automatic logic [11:0] spr_rom(input logic [17:0] a);
      if (a % 5 == 2) return 12'hfff;
      return 12'((a * 29 + 7) % 4095);
   endfunction

   function automatic logic [11:0] bg_rom(input logic [17:0] a);
      return 12'((a * 11 + 300) % 4096);
   endfunction

   // Board RAM and both ROMs answer one clock after the address
   always @(posedge clk) begin
      kind     <= 3'(board[cell_y][cell_x]);
      spr_data <= spr_rom(spr_addr);
      bg_data  <= bg_rom(bg_addr);
   end

   // ---------------- reference model ----------------
   function automatic bit in_board(input int px, input int py);
      return px >= 220 && px < 420 && py >= 40 && py < 440;
   endfunction

   function automatic int digit_at(input int px, input int py);
      if (py < 450 || py >= 468) return -1;
      for (int n = 0; n < 4; n++)
         if (px >= 128 + 14 * n && px < 138 + 14 * n) return n;
      return -1;
   endfunction

   function automatic int digit_val(input int n);
      return int'((score >> (4 * (3 - n))) & 16'hf);
   endfunction

   function automatic bit digit_blank(input int n);
      if (n == 3) return 1'b0;
      for (int j = 0; j <= n; j++)
         if (digit_val(j) != 0) return 1'b0;
      return 1'b1;
   endfunction

   // sprite ROM address for a pixel, or -1 when it has no sprite source
   function automatic int model_spr(input int px, input int py);
      int k, n, v;
      if (in_board(px, py)) begin
         k = board[(py - 40) / 20][(px - 220) / 20];
         if (k == 0) return -1;
         return (k - 1) * 100 + ((py - 40) % 20 / 2) * 10 + (px - 220) % 20 / 2;
      end
      n = digit_at(px, py);
      if (n < 0) return -1;
      v = digit_val(n);
      if (v > 9 || digit_blank(n)) return -1;
      return 700 + v * 45 + ((py - 450) / 2) * 5 + (px - (128 + 14 * n)) / 2;
   endfunction

   function automatic logic [11:0] model_rgb(input int px, input int py, input bit vis);
      int a;
      if (!vis) return 12'h000;
      if (in_board(px, py) && m_active && (m_cnt % 2 == 1) && m_mask[(py - 40) / 20])
         return 12'hfff;
      a = model_spr(px, py);
      if (a >= 0 && spr_rom(18'(a)) != 12'hfff) return spr_rom(18'(a));
      return bg_rom(18'((py / 2) * 320 + px / 2));
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // one clock; inputs change on the falling edge, p_tick every 4th clock
   task automatic clk1();
      @(negedge clk);
      tick_cnt = (tick_cnt + 1) % 4;
      p_tick   = (tick_cnt == 0);
   endtask

   task automatic probe(input int px, input int py, input bit vis, input string tag);
      int ea;
      pixel_x = 10'(px);
      pixel_y = 10'(py);
      visible = vis;
      repeat (10) clk1();
      check({tag, ".rgb"}, 32'(rgb), 32'(model_rgb(px, py, vis)));
      check({tag, ".cell_x"}, 32'(cell_x), in_board(px, py) ? 32'((px - 220) / 20) : 32'd0);
      check({tag, ".cell_y"}, 32'(cell_y), in_board(px, py) ? 32'((py - 40) / 20) : 32'd0);
      check({tag, ".bg_addr"}, 32'(bg_addr), 32'((py / 2) * 320 + px / 2));
      ea = model_spr(px, py);
      if (ea >= 0) check({tag, ".spr_addr"}, 32'(spr_addr), 32'(ea));
   endtask

   task automatic start_req(input logic [19:0] rows, input string tag);
      flash_start = 1'b1;
      flash_rows  = rows;
      clk1();
      flash_start = 1'b0;
      if (!m_active && rows != 0) begin
         m_active = 1'b1; m_cnt = 0; m_mask = rows;
      end
      check({tag, ".busy"}, 32'(flash_busy), 32'(m_active));
      check({tag, ".done"}, 32'(flash_done), 32'd0);
   endtask

   task automatic frame_pulse(input bit with_start, input logic [19:0] rows, input string tag);
      bit pre_active;
      bit exp_done;
      pre_active  = m_active;
      exp_done    = 1'b0;
      frame_start = 1'b1;
      flash_start = with_start;
      flash_rows  = rows;
      clk1();
      frame_start = 1'b0;
      flash_start = 1'b0;
      if (pre_active) begin
         m_cnt++;
         if (m_cnt == 8) begin m_active = 1'b0; exp_done = 1'b1; end
      end else if (with_start && rows != 0) begin
         m_active = 1'b1; m_cnt = 0; m_mask = rows;
      end
      check({tag, ".busy"}, 32'(flash_busy), 32'(m_active));
      check({tag, ".done"}, 32'(flash_done), 32'(exp_done));
   endtask

   function automatic logic [15:0] rand_score();
      logic [15:0] s;
      s = '0;
      for (int i = 0; i < 4; i++)
         s = {s[11:0], ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 11))};
      return s;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int px, py, r, pre_addr;
      bit vis;

      for (int y = 0; y < 20; y++)
         for (int x = 0; x < 10; x++) board[y][x] = 3;

      // reset state
      repeat (3) clk1();
      check("rst.rgb", 32'(rgb), 32'd0);
      check("rst.spr_addr", 32'(spr_addr), 32'd0);
      check("rst.bg_addr", 32'(bg_addr), 32'd0);
      check("rst.cell", 32'({cell_y, cell_x}), 32'd0);
      check("rst.busy", 32'(flash_busy), 32'd0);
      check("rst.done", 32'(flash_done), 32'd0);
      reset_n = 1'b1;
      clk1();

      // kind=3 everywhere: address timing at the board corner
      probe(419, 439, 1'b1, "t1.prev");
      pre_addr = model_spr(419, 439);
      pixel_x = 10'd221; pixel_y = 10'd41;
      clk1();   // cell address registered
      check("t1.cell_xy", 32'({cell_y, cell_x}), 32'd0);
      check("t1.spr_old0", 32'(spr_addr), 32'(pre_addr));
      clk1();   // board RAM returns kind
      check("t1.spr_old1", 32'(spr_addr), 32'(pre_addr));
      clk1();   // sprite address formed from kind
      check("t1.spr_addr", 32'(spr_addr), 32'd200);
      repeat (7) clk1();
      check("t1.rgb", 32'(rgb), 32'(spr_rom(18'd200)));

      // random board, transparent sprite word and blanked video
      for (int y = 0; y < 20; y++)
         for (int x = 0; x < 10; x++) board[y][x] = $urandom_range(0, 7);
      board[0][0] = 1;
      probe(224, 40, 1'b1, "t3.transp");
      probe(224, 40, 1'b0, "t3.invis_board");
      probe(160, 455, 1'b0, "t3.invis_digit");

      // score digits and leading-zero blanking
      score = 16'h0042;
      probe(131, 452, 1'b1, "t2.d0_blank");
      probe(145, 452, 1'b1, "t2.d1_blank");
      probe(159, 452, 1'b1, "t2.d2_four");
      probe(173, 452, 1'b1, "t2.d3_two");
      probe(139, 452, 1'b1, "t2.gap");
      score = 16'h0000;
      probe(171, 460, 1'b1, "t2.zero_ls");
      probe(157, 460, 1'b1, "t2.zero_d2");
      score = 16'h0A05;
      probe(145, 451, 1'b1, "t2.invalid");
      probe(157, 466, 1'b1, "t2.inner_zero");

      // random probes
      for (int i = 0; i < 40; i++) begin
         if (i % 8 == 0) score = rand_score();
         r = $urandom_range(0, 9);
         if (r < 5) begin
            px = $urandom_range(220, 419); py = $urandom_range(40, 439);
         end else if (r < 7) begin
            px = $urandom_range(120, 190); py = $urandom_range(445, 470);
         end else begin
            px = $urandom_range(0, 639); py = $urandom_range(0, 479);
         end
         vis = ($urandom_range(0, 9) != 0);
         probe(px, py, vis, "rnd");
      end

      // flash sequence
      frame_pulse(1'b0, 20'h0, "t4.idle_frame");
      start_req(20'h00000, "t4.empty_req");
      start_req(20'h80001, "t4.start");
      for (int f = 1; f <= 8; f++) begin
         frame_pulse(1'b0, 20'h0, "t4.frame");
         if (f == 3) start_req(20'h00002, "t4.ignored_req");
         if (f < 8) begin
            probe(225, 45, 1'b1, "t4.row0");
            probe(300, 430, 1'b1, "t4.row19");
            probe(300, 65, 1'b1, "t4.row1");
         end
      end
      clk1();
      check("t4.done_pulse_end", 32'(flash_done), 32'd0);
      probe(225, 45, 1'b1, "t4.after");

      // start request coinciding with the final frame is dropped
      start_req(20'h00010, "t4b.start");
      for (int f = 1; f <= 7; f++) frame_pulse(1'b0, 20'h0, "t4b.frame");
      frame_pulse(1'b1, 20'h00100, "t4b.final_and_start");
      clk1();
      check("t4b.still_idle", 32'(flash_busy), 32'd0);

      // reset in the middle of a sequence
      start_req(20'hfffff, "t5.start");
      frame_pulse(1'b0, 20'h0, "t5.frame");
      frame_pulse(1'b0, 20'h0, "t5.frame");
      reset_n = 1'b0;
      clk1();
      m_active = 1'b0;
      check("t5.busy", 32'(flash_busy), 32'd0);
      check("t5.done", 32'(flash_done), 32'd0);
      check("t5.rgb", 32'(rgb), 32'd0);
      check("t5.spr_addr", 32'(spr_addr), 32'd0);
      reset_n = 1'b1;
      clk1();
      check("t5.no_done", 32'(flash_done), 32'd0);
      probe(420, 100, 1'b1, "t5.edge_out");
      probe(419, 100, 1'b1, "t5.edge_in");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
